// File: rtl/dmem_arbiter_if.sv
// Data-memory bus bundle: request fields towards memory, grant/read-return/error back.
// Requester ports use master/slave; the memory port uses mem_master/mem_slave, which have no err.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32
) ();
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [3:0]        be;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;
  logic              err;

  modport master (
    output req, we, addr, wdata, be,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output gnt, rvalid, rdata, err
  );

  modport mem_master (
    output req, we, addr, wdata, be,
    input  gnt, rvalid, rdata
  );

  modport mem_slave (
    input  req, we, addr, wdata, be,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the core LSU (m0) and debug/DMA (m1).
// Optional transaction timeout is enabled with the macro DMEM_ARB_TIMEOUT_EN.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  dmem_arbiter_if.slave        m0,
  dmem_arbiter_if.slave        m1,
  dmem_arbiter_if.mem_master   mem,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_R = 2'd2
  } state_e;

  state_e            state_q,      state_d;
  logic              owner_q,      owner_d;
  logic              last_grant_q, last_grant_d;
  logic              req_q,        req_d;
  logic              we_q,         we_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic [31:0]       wdata_q,      wdata_d;
  logic [3:0]        be_q,         be_d;
  logic              rvalid0_q,    rvalid0_d;
  logic              rvalid1_q,    rvalid1_d;
  logic [31:0]       rdata0_q,     rdata0_d;
  logic [31:0]       rdata1_q,     rdata1_d;
  logic              busy_q,       busy_d;
  logic              win_s;

`ifdef DMEM_ARB_TIMEOUT_EN
  localparam logic [4:0] TMO_LAST = 5'(MAX_WAIT - 1);

  logic [4:0]        cnt_q,        cnt_d;
  logic              err0_q,       err0_d;
  logic              err1_q,       err1_d;
`endif

  // Next-state, capture and return-path logic.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    rvalid0_d    = 1'b0;
    rvalid1_d    = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    win_s        = 1'b0;
`ifdef DMEM_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (m0.req || m1.req) begin
          // On a tie the port that did not win last time goes first.
          if (m0.req && m1.req) begin
            win_s = ~last_grant_q;
          end else begin
            win_s = m1.req;
          end
          owner_d      = win_s;
          last_grant_d = win_s;
          we_d         = win_s ? m1.we    : m0.we;
          addr_d       = win_s ? m1.addr  : m0.addr;
          wdata_d      = win_s ? m1.wdata : m0.wdata;
          be_d         = win_s ? m1.be    : m0.be;
          req_d        = 1'b1;
          state_d      = ISSUE;
`ifdef DMEM_ARB_TIMEOUT_EN
          cnt_d        = 5'd0;
`endif
        end else begin
          state_d = IDLE;
        end
      end

      ISSUE: begin
        if (mem.gnt) begin
          req_d   = 1'b0;
          state_d = we_q ? IDLE : WAIT_R;
`ifdef DMEM_ARB_TIMEOUT_EN
          cnt_d   = 5'd0;
`endif
        end else begin
`ifdef DMEM_ARB_TIMEOUT_EN
          if (cnt_q == TMO_LAST) begin
            req_d   = 1'b0;
            state_d = IDLE;
            err0_d  = ~owner_q;
            err1_d  = owner_q;
          end else begin
            cnt_d   = cnt_q + 5'd1;
          end
`else
          req_d = 1'b1;
`endif
        end
      end

      WAIT_R: begin
        if (mem.rvalid) begin
          state_d = IDLE;
          if (owner_q) begin
            rvalid1_d = 1'b1;
            rdata1_d  = mem.rdata;
          end else begin
            rvalid0_d = 1'b1;
            rdata0_d  = mem.rdata;
          end
        end else begin
`ifdef DMEM_ARB_TIMEOUT_EN
          if (cnt_q == TMO_LAST) begin
            state_d = IDLE;
            err0_d  = ~owner_q;
            err1_d  = owner_q;
          end else begin
            cnt_d   = cnt_q + 5'd1;
          end
`else
          state_d = WAIT_R;
`endif
        end
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered-output flops; reset kills any transaction in flight.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'h0000_0000;
      be_q         <= 4'h0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata0_q     <= 32'h0000_0000;
      rdata1_q     <= 32'h0000_0000;
      busy_q       <= 1'b0;
`ifdef DMEM_ARB_TIMEOUT_EN
      cnt_q        <= 5'd0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      busy_q       <= busy_d;
`ifdef DMEM_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
`endif
    end
  end

  assign mem.req   = req_q;
  assign mem.we    = we_q;
  assign mem.addr  = addr_q;
  assign mem.wdata = wdata_q;
  assign mem.be    = be_q;

  // Grant is passed straight through so the requester sees it in the memory's accept cycle.
  assign m0.gnt    = mem.gnt && (state_q == ISSUE) && !owner_q;
  assign m1.gnt    = mem.gnt && (state_q == ISSUE) &&  owner_q;

  assign m0.rvalid = rvalid0_q;
  assign m1.rvalid = rvalid1_q;
  assign m0.rdata  = rdata0_q;
  assign m1.rdata  = rdata1_q;

`ifdef DMEM_ARB_TIMEOUT_EN
  assign m0.err    = err0_q;
  assign m1.err    = err1_q;
`else
  assign m0.err    = 1'b0;
  assign m1.err    = 1'b0;
`endif

  assign busy_o    = busy_q;

endmodule
